// File: rtl/aes_128_pkg.sv
// Register map, control/status bit positions and AXI response codes shared by the
// AES-128 AXI4-Lite slave and anything that talks to it.
package aes_128_pkg;

    localparam logic [5:0] ADDR_KEY0   = 6'h00;
    localparam logic [5:0] ADDR_PT0    = 6'h10;
    localparam logic [5:0] ADDR_CTRL   = 6'h20;
    localparam logic [5:0] ADDR_STATUS = 6'h24;
    localparam logic [5:0] ADDR_CT0    = 6'h28;
    localparam logic [5:0] ADDR_RSVD0  = 6'h38;

    localparam logic [3:0] WIDX_KEY0   = ADDR_KEY0[5:2];
    localparam logic [3:0] WIDX_PT0    = ADDR_PT0[5:2];
    localparam logic [3:0] WIDX_CTRL   = ADDR_CTRL[5:2];
    localparam logic [3:0] WIDX_STATUS = ADDR_STATUS[5:2];
    localparam logic [3:0] WIDX_CT0    = ADDR_CT0[5:2];
    localparam logic [3:0] WIDX_RSVD0  = ADDR_RSVD0[5:2];

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_DONE  = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    typedef enum logic [2:0] {
        REG_KEY,
        REG_PT,
        REG_CTRL,
        REG_STATUS,
        REG_CT,
        REG_RSVD
    } reg_sel_t;

    function automatic reg_sel_t decode_word(input logic [3:0] widx);
        reg_sel_t sel;
        if (widx < WIDX_PT0)
            sel = REG_KEY;
        else if (widx < WIDX_CTRL)
            sel = REG_PT;
        else if (widx == WIDX_CTRL)
            sel = REG_CTRL;
        else if (widx == WIDX_STATUS)
            sel = REG_STATUS;
        else if (widx < WIDX_RSVD0)
            sel = REG_CT;
        else
            sel = REG_RSVD;
        return sel;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/aes_128_axil_slave.sv
// AXI4-Lite register front end for an external AES-128 core: key/plaintext staging,
// start/done handshake, ciphertext capture and a level interrupt.
//
// state        | meaning
// WR_IDLE      | no write beat captured yet
// WR_HAVE_ADDR | AW captured, waiting for W
// WR_HAVE_DATA | W captured, waiting for AW
// WR_RESP      | register updated, BVALID held until BREADY
// RD_IDLE      | ARREADY high, waiting for AR
// RD_RESP      | RDATA/RRESP held until RREADY
module aes_128_axil_slave
    import aes_128_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [127:0]                    core_key,
    output logic [127:0]                    core_pt,
    output logic                            core_start,
    input  logic [127:0]                    core_ct,
    input  logic                            core_done,
    output logic                            irq
);

    logic [31:0] key_w [4];
    logic [31:0] pt_w  [4];
    logic [31:0] ct_w  [4];
    logic        irq_en_q;
    logic        busy_q;
    logic        done_q;
    logic        core_start_q;
    logic        irq_q;

    wr_state_t   wr_state, wr_state_nxt;
    logic [3:0]  aw_widx_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;

    rd_state_t   rd_state, rd_state_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [3:0]  wr_widx, rd_widx;
    logic [1:0]  ct_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    reg_sel_t    wr_sel, rd_sel;
    logic        unused_addr_bits;

    // Only the word index matters; byte-lane address bits are ignored.
    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = !ARESET && (wr_state == WR_IDLE || wr_state == WR_HAVE_DATA);
    assign S_AXI_WREADY  = !ARESET && (wr_state == WR_IDLE || wr_state == WR_HAVE_ADDR);
    assign S_AXI_BVALID  = !ARESET && (wr_state == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !ARESET && (rd_state == RD_IDLE);
    assign S_AXI_RVALID  = !ARESET && (rd_state == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // The beat completing the pair is used straight from the bus so the update
    // lands on the same edge as the last handshake.
    assign wr_widx = (wr_state == WR_HAVE_ADDR) ? aw_widx_q : S_AXI_AWADDR[5:2];
    assign wr_data = (wr_state == WR_HAVE_DATA) ? w_data_q  : S_AXI_WDATA;
    assign wr_strb = (wr_state == WR_HAVE_DATA) ? w_strb_q  : S_AXI_WSTRB;
    assign wr_fire = (aw_hs || wr_state == WR_HAVE_ADDR) && (w_hs || wr_state == WR_HAVE_DATA);
    assign wr_sel  = decode_word(wr_widx);

    assign rd_widx = S_AXI_ARADDR[5:2];
    assign rd_sel  = decode_word(rd_widx);
    assign ct_idx  = rd_widx[1:0] - WIDX_CT0[1:0];

    assign core_key   = {key_w[0], key_w[1], key_w[2], key_w[3]};
    assign core_pt    = {pt_w[0], pt_w[1], pt_w[2], pt_w[3]};
    assign core_start = core_start_q;
    assign irq        = irq_q;

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs)
                    wr_state_nxt = WR_RESP;
                else if (aw_hs)
                    wr_state_nxt = WR_HAVE_ADDR;
                else if (w_hs)
                    wr_state_nxt = WR_HAVE_DATA;
            end
            WR_HAVE_ADDR: if (w_hs)  wr_state_nxt = WR_RESP;
            WR_HAVE_DATA: if (aw_hs) wr_state_nxt = WR_RESP;
            WR_RESP:      if (S_AXI_BREADY) wr_state_nxt = WR_IDLE;
            default:      wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state  <= WR_IDLE;
            aw_widx_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            wr_state <= wr_state_nxt;
            if (aw_hs)
                aw_widx_q <= S_AXI_AWADDR[5:2];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                key_w[i] <= '0;
                pt_w[i]  <= '0;
                ct_w[i]  <= '0;
            end
            irq_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_start_q <= 1'b0;
            irq_q        <= 1'b0;
            bresp_q      <= RESP_OKAY;
        end else begin
            core_start_q <= 1'b0;
            irq_q        <= done_q & irq_en_q;
            if (wr_fire) begin
                bresp_q <= (wr_sel == REG_RSVD) ? RESP_SLVERR : RESP_OKAY;
                case (wr_sel)
                    REG_KEY: if (!busy_q)
                        key_w[wr_widx[1:0]] <= apply_wstrb(key_w[wr_widx[1:0]], wr_data, wr_strb);
                    REG_PT: if (!busy_q)
                        pt_w[wr_widx[1:0]] <= apply_wstrb(pt_w[wr_widx[1:0]], wr_data, wr_strb);
                    REG_CTRL: if (wr_strb[0]) begin
                        irq_en_q <= wr_data[CTRL_IRQ_EN];
                        if (wr_data[CTRL_START] && !busy_q) begin
                            core_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                        end
                    end
                    REG_STATUS: if (wr_strb[0] && wr_data[STATUS_DONE])
                        done_q <= 1'b0;
                    default: ;
                endcase
            end
            // Placed after the W1C so a coincident completion keeps DONE set.
            if (core_done && busy_q) begin
                for (int i = 0; i < 4; i++)
                    ct_w[i] <= core_ct[127-32*i -: 32];
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)        rd_state_nxt = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) rd_state_nxt = RD_IDLE;
            default:                   rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        rdata_nxt = '0;
        case (rd_sel)
            REG_KEY:    rdata_nxt = key_w[rd_widx[1:0]];
            REG_PT:     rdata_nxt = pt_w[rd_widx[1:0]];
            REG_CTRL:   rdata_nxt[CTRL_IRQ_EN] = irq_en_q;
            REG_STATUS: begin
                rdata_nxt[STATUS_BUSY] = busy_q;
                rdata_nxt[STATUS_DONE] = done_q;
            end
            REG_CT:     rdata_nxt = ct_w[ct_idx];
            default:    rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_nxt;
            if (ar_hs) begin
                rdata_q <= rdata_nxt;
                rresp_q <= (rd_sel == REG_RSVD) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_aes_128_axil_slave.sv
// Directed bench for aes_128_axil_slave with a behavioural AES core stand-in.
module tb_aes_128_axil_slave;

    localparam logic [127:0] CT_EXP   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           CORE_LAT = 10;

    logic         ACLK;
    logic         ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] core_key;
    logic [127:0] core_pt;
    logic         core_start;
    logic [127:0] core_ct;
    logic         core_done;
    logic         irq;

    int n_chk     = 0;
    int n_pass    = 0;
    int start_cnt = 0;
    int core_cnt  = 0;
    int man_req   = 0;
    int man_seen  = 0;
    bit auto_core = 1'b0;

    aes_128_axil_slave dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .core_key      (core_key),
        .core_pt       (core_pt),
        .core_start    (core_start),
        .core_ct       (core_ct),
        .core_done     (core_done),
        .irq           (irq)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) if (core_start) start_cnt++;

    // Core stand-in: done CORE_LAT cycles after start when auto_core, or on request.
    initial begin
        core_done = 1'b0;
        core_ct   = '0;
        forever begin
            @(posedge ACLK); #2;
            core_done = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done = 1'b1;
                    core_ct   = CT_EXP;
                end
            end else if (core_start && auto_core) begin
                core_cnt = CORE_LAT;
            end
            if (man_req != man_seen) begin
                core_done = 1'b1;
                core_ct   = CT_EXP;
                man_seen  = man_req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int skew,
                             input bit with_done, output logic [1:0] resp);
        bit aw_done;
        bit w_done;
        int t;
        aw_done = 1'b0;
        w_done  = 1'b0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        if (with_done) man_req++;
        for (t = 0; t < 30 && !(aw_done && w_done); t++) begin
            S_AXI_AWVALID = !aw_done && (t >= ((skew > 0) ? skew : 0));
            S_AXI_WVALID  = !w_done  && (t >= ((skew < 0) ? -skew : 0));
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY)   w_done  = 1'b1;
            @(posedge ACLK); #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accepted", {aw_done, w_done}, 2'b11);
        @(negedge ACLK);
        t = 0;
        while (!S_AXI_BVALID && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("bvalid", S_AXI_BVALID, 1'b1);
        @(negedge ACLK);
        check("bvalid_hold", S_AXI_BVALID, 1'b1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        check("bvalid_single", S_AXI_BVALID, 1'b0);
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int t;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        t = 0;
        while (!S_AXI_ARREADY && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("arready", S_AXI_ARREADY, 1'b1);
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        t = 0;
        while (!S_AXI_RVALID && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check("rvalid", S_AXI_RVALID, 1'b1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    logic [31:0] key_vec [4];
    logic [31:0] pt_vec  [4];
    logic [31:0] ct_vec  [4];

    initial begin
        logic [31:0] rd;
        logic [1:0]  resp;
        int          s0;
        int          t;

        key_vec = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        pt_vec  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        ct_vec  = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0;  S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;

        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_arready", S_AXI_ARREADY, 1'b0);
        check("rst_awready", S_AXI_AWREADY, 1'b0);
        check("rst_wready", S_AXI_WREADY, 1'b0);
        check("rst_bvalid", S_AXI_BVALID, 1'b0);
        check("rst_rvalid", S_AXI_RVALID, 1'b0);
        check("rst_core_start", core_start, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_core_key", core_key, 128'h0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("arready_after_rst", S_AXI_ARREADY, 1'b1);
        @(posedge ACLK); #1;
        axi_read(6'h24, rd, resp);
        check("rst_status", rd, 32'h0);

        // Key load and readback
        for (int i = 0; i < 4; i++) begin
            axi_write(6'(4*i), key_vec[i], 4'hf, 0, 1'b0, resp);
            check("key_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(4*i), rd, resp);
            check("key_rdata", rd, key_vec[i]);
            check("key_rresp", resp, 2'b00);
        end
        check("core_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);

        // Plaintext with W-before-AW and AW-before-W orderings
        axi_write(6'h10, pt_vec[0], 4'hf, 3, 1'b0, resp);
        check("pt0_w_first_bresp", resp, 2'b00);
        axi_write(6'h14, pt_vec[1], 4'hf, -3, 1'b0, resp);
        check("pt1_aw_first_bresp", resp, 2'b00);
        axi_write(6'h18, pt_vec[2], 4'hf, 0, 1'b0, resp);
        axi_write(6'h1c, pt_vec[3], 4'hf, 0, 1'b0, resp);
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(16 + 4*i), rd, resp);
            check("pt_rdata", rd, pt_vec[i]);
        end
        check("core_pt", core_pt, 128'h00112233445566778899aabbccddeeff);

        // Encryption run with interrupt enabled
        auto_core = 1'b1;
        s0 = start_cnt;
        axi_write(6'h20, 32'h3, 4'hf, 0, 1'b0, resp);
        axi_read(6'h24, rd, resp);
        check("status_busy", rd, 32'h1);
        t = 0;
        while (!irq && t < 60) begin
            @(negedge ACLK);
            t++;
        end
        check("irq_after_done", irq, 1'b1);
        @(posedge ACLK); #1;
        check("one_start_pulse", start_cnt - s0, 1);
        axi_read(6'h24, rd, resp);
        check("status_done", rd, 32'h2);
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(40 + 4*i), rd, resp);
            check("ct_rdata", rd, ct_vec[i]);
        end
        axi_read(6'h20, rd, resp);
        check("ctrl_start_reads_0", rd, 32'h2);

        // START and key write while busy
        auto_core = 1'b0;
        s0 = start_cnt;
        axi_write(6'h20, 32'h3, 4'hf, 0, 1'b0, resp);
        axi_read(6'h24, rd, resp);
        check("busy_done_cleared", rd, 32'h1);
        axi_write(6'h20, 32'h3, 4'hf, 0, 1'b0, resp);
        check("start_busy_bresp", resp, 2'b00);
        check("no_second_pulse", start_cnt - s0, 1);
        axi_write(6'h00, 32'hdeadbeef, 4'hf, 0, 1'b0, resp);
        check("key_busy_bresp", resp, 2'b00);
        axi_read(6'h00, rd, resp);
        check("key0_unchanged", rd, 32'h00010203);
        axi_read(6'h38, rd, resp);
        check("rsvd38_rresp", resp, 2'b10);
        check("rsvd38_rdata", rd, 32'h0);
        axi_read(6'h3c, rd, resp);
        check("rsvd3c_rresp", resp, 2'b10);
        axi_write(6'h38, 32'hffffffff, 4'hf, 0, 1'b0, resp);
        check("rsvd38_bresp", resp, 2'b10);
        axi_write(6'h28, 32'h12345678, 4'hf, 0, 1'b0, resp);
        check("ct_ro_bresp", resp, 2'b00);
        axi_read(6'h28, rd, resp);
        check("ct0_ro_unchanged", rd, 32'h69c4e0d8);

        // DONE W1C coinciding with core_done: set wins
        axi_write(6'h24, 32'h2, 4'hf, 0, 1'b1, resp);
        axi_read(6'h24, rd, resp);
        check("done_set_wins", rd, 32'h2);
        check("irq_set_wins", irq, 1'b1);
        axi_write(6'h24, 32'h2, 4'hf, 0, 1'b0, resp);
        axi_read(6'h24, rd, resp);
        check("done_w1c", rd, 32'h0);
        repeat (2) @(posedge ACLK); #1;
        check("irq_cleared", irq, 1'b0);

        // Byte strobes
        axi_write(6'h04, 32'h0, 4'hf, 0, 1'b0, resp);
        axi_write(6'h04, 32'haabbccdd, 4'b0010, 0, 1'b0, resp);
        axi_read(6'h04, rd, resp);
        check("wstrb_lane1", rd, 32'h0000cc00);

        // Reset mid-operation and mid-write
        axi_write(6'h20, 32'h1, 4'hf, 0, 1'b0, resp);
        axi_read(6'h24, rd, resp);
        check("busy_before_rst", rd, 32'h1);
        S_AXI_AWADDR  = 6'h00;
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK); #1;
        ARESET = 1'b0;
        man_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check("no_bvalid_after_rst", S_AXI_BVALID, 1'b0);
        end
        @(posedge ACLK); #1;
        axi_read(6'h24, rd, resp);
        check("status_after_rst_done", rd, 32'h0);
        axi_read(6'h28, rd, resp);
        check("ct0_after_rst_done", rd, 32'h0);
        axi_read(6'h00, rd, resp);
        check("key0_after_rst", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_128_axil_slave.md
AES_128_AXIL_SLAVE -- requirements
Module: aes_128_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 6, byte address width.
REQ-003 ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 ARESET  in  1  synchronous, active-high reset.
REQ-005 S_AXI_AWADDR in 6, AWVALID in 1, AWREADY out 1: write address channel.
REQ-006 S_AXI_WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
REQ-007 S_AXI_BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-008 S_AXI_ARADDR in 6, ARVALID in 1, ARREADY out 1: read address channel.
REQ-009 S_AXI_RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
REQ-010 core_key out 128, core_pt out 128, core_start out 1: operands and one-cycle start pulse to the AES core.
REQ-011 core_ct in 128, core_done in 1: ciphertext and one-cycle completion pulse from the AES core.
REQ-012 irq out 1: level interrupt.

Function
REQ-013 Register map (word-aligned, AWADDR/ARADDR[1:0] ignored): 0x00-0x0C KEY0-3 RW; 0x10-0x1C PT0-3 RW; 0x20 CTRL RW (bit0 START, bit1 IRQ_EN); 0x24 STATUS (bit0 BUSY RO, bit1 DONE W1C); 0x28-0x34 CT0-3 RO.
REQ-014 Word 0 of each 128-bit group SHALL map to bits [127:96], word 3 to bits [31:0].
REQ-015 Write FSM states WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP; AW and W SHALL be accepted independently, in either order or the same cycle; AWREADY/WREADY high only while the respective beat is not yet captured and state is not WR_RESP.
REQ-016 Register update SHALL occur on the cycle both address and data are held; BVALID asserts the following cycle and holds until BREADY; one outstanding write.
REQ-017 WSTRB SHALL gate each byte lane of RW registers.
REQ-018 Read FSM states RD_IDLE, RD_RESP; ARREADY high in RD_IDLE; RVALID asserts the cycle after AR handshake; RDATA/RRESP stable until RREADY.
REQ-019 Addresses 0x38-0x3C SHALL return SLVERR (2'b10), RDATA 0, no state change; all others return OKAY, including writes to RO locations, which are ignored.
REQ-020 Writing CTRL with START=1 while not BUSY SHALL pulse core_start for exactly one cycle (the cycle after the register update), set BUSY, clear DONE; START reads back 0.
REQ-021 START written while BUSY SHALL be ignored (no pulse, OKAY).
REQ-022 KEY/PT writes while BUSY SHALL be dropped (OKAY); core_key/core_pt are the KEY/PT registers directly.
REQ-023 On core_done: CT captured from core_ct, BUSY cleared, DONE set; core_done while not BUSY ignored.
REQ-024 core_done coinciding with a DONE W1C write: set SHALL win.
REQ-025 irq SHALL equal DONE & IRQ_EN, registered, one cycle after either changes.
REQ-026 Reads of STATUS SHALL reflect the value at AR handshake.

Reset
REQ-027 On ARESET: all registers 0, both FSMs idle, AWREADY/WREADY/BVALID/RVALID/core_start/irq 0, ARREADY 0 during reset and 1 the first cycle after.
REQ-028 ARESET mid-transaction SHALL abort it with no response issued; an in-flight core operation is forgotten (BUSY 0, later core_done ignored).

Structure
REQ-029 Register offsets, CTRL/STATUS bit indices, and RESP codes SHALL live in shared package aes_128_pkg.
REQ-030 Single module, no sub-modules; the AES core is instantiated by the parent.

Verification
REQ-031 Write KEY0-3 = 00010203,04050607,08090a0b,0c0d0e0f; read back -> identical, RRESP OKAY.
REQ-032 Write PT = 00112233..ccddeeff, CTRL=0x3, model core returns done after 10 cycles -> one core_start pulse, BUSY=1 then 0, CT0-3 = 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, DONE=1, irq=1.
REQ-033 W beat 3 cycles before AW, then AW before W -> both OKAY, correct data written, single BVALID each.
REQ-034 WSTRB=4'b0010 data 0xAABBCCDD to KEY1=0 -> reads 0x0000CC00.
REQ-035 CTRL START while BUSY, KEY0 write while BUSY -> no second pulse, KEY0 unchanged; read 0x38 -> SLVERR, data 0.
REQ-036 Write STATUS=0x2 same cycle as core_done -> DONE stays 1; subsequent W1C -> DONE 0, irq 0.
